// File: rtl/uart_rx_framer.sv
// uart_rx_framer: UART receiver feeding the write side of a circular FIFO.
// Deserialises LSB-first 8N1 frames (8E1 when UART_RX_PARITY_EN is defined),
// and hands each good byte to the FIFO as datainput plus a one-cycle push.
// Bytes completing while the FIFO reports full are dropped and flagged.
//
// Ports:
//   clk         uart-domain clock, all logic on posedge
//   reset       synchronous active-low reset
//   rx          asynchronous serial line, idle high
//   full        FIFO full flag, consulted only at the stop-bit decision
//   datainput   last accepted byte, updated only together with push
//   push        one-cycle FIFO write strobe
//   frame_err   one-cycle pulse, stop bit sampled low
//   overrun     one-cycle pulse, good frame dropped because full was high
//   parity_err  one-cycle pulse, even-parity mismatch (0 unless UART_RX_PARITY_EN)
//   busy        high from start-bit detect until the FSM is back in IDLE
//
// Configuration macro: UART_RX_PARITY_EN (adds an even parity bit after the data).

module uart_rx_framer #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  input  logic                  full,
  output logic [DATA_WIDTH-1:0] datainput,
  output logic                  push,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  parity_err,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t                state, state_d;
  logic                  rx_meta, rx_s;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic [BIT_W-1:0]      bit_cnt, bit_d;
  logic [DATA_WIDTH-1:0] shift, shift_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  push_d, ferr_d, ovr_d, perr_d, busy_d;
  logic                  tick_c;
`ifdef UART_RX_PARITY_EN
  logic                  par_bit, par_d;
`endif

  // One full bit period has elapsed since the last mid-bit sample.
  assign tick_c = (cnt == FULL_M1);

  // Two-flop synchroniser, state register and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      state      <= S_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      datainput  <= '0;
      push       <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      state      <= state_d;
      cnt        <= cnt_d;
      bit_cnt    <= bit_d;
      shift      <= shift_d;
      datainput  <= data_d;
      push       <= push_d;
      frame_err  <= ferr_d;
      overrun    <= ovr_d;
      parity_err <= perr_d;
      busy       <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bit    <= par_d;
`endif
    end
  end

  // Next-state, counter, shift register and output-strobe logic.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bit_d   = bit_cnt;
    shift_d = shift;
    data_d  = datainput;
    push_d  = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_bit;
`endif

    case (state)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        // Low line in IDLE can only follow a 1->0 edge: BREAK exits on high.
        if (!rx_s) state_d = S_START;
      end

      S_START: begin
        if (cnt == HALF_M1) begin
          cnt_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (tick_c) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift[DATA_WIDTH-1:1]};
          bit_d   = bit_cnt + BIT_W'(1);
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick_c) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
`endif

      S_STOP: begin
        if (tick_c) begin
          cnt_d = '0;
          if (!rx_s) begin
            // Frame error outranks parity; BREAK absorbs a held-low line.
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end else begin
            // Returning at mid-stop leaves half a bit to catch the next start.
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (^{shift, par_bit}) perr_d = 1'b1;
            else
`endif
            if (full) begin
              ovr_d = 1'b1;
            end else begin
              push_d = 1'b1;
              data_d = shift;
            end
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      S_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: self-checking bench for uart_rx_framer at 16 clocks per bit.
// Frames are built bit by bit on rx; a negedge monitor records every strobe,
// and each scenario task compares those records against outcomes derived
// from the frame contents (stop bit, parity, full at the stop decision).
// Honours UART_RX_PARITY_EN to send 8E1 frames.

module tb_uart_rx_framer;

  localparam int unsigned CPB = 16;
  localparam int unsigned DW  = 8;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  // Mid stop bit, plus the two synchroniser flops, plus the registered strobe.
  localparam int unsigned LAT = (NBITS - 1) * CPB + CPB / 2 + 3;

  localparam int OUT_PUSH = 0;
  localparam int OUT_FERR = 1;
  localparam int OUT_PERR = 2;
  localparam int OUT_OVR  = 3;

  logic          clk;
  logic          reset;
  logic          rx;
  logic          full;
  logic [DW-1:0] datainput;
  logic          push, frame_err, overrun, parity_err, busy;

  uart_rx_framer #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .full       (full),
    .datainput  (datainput),
    .push       (push),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor records
  logic [DW-1:0] push_q[$];
  int unsigned   push_cyc_q[$];
  int            n_ferr, n_ovr, n_perr, n_excl, n_long, n_chg;
  bit            busy_seen;
  logic          prev_push = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0, prev_perr = 1'b0;
  logic [DW-1:0] prev_data;
  logic [DW-1:0] exp_data;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (push) begin
        push_q.push_back(datainput);
        push_cyc_q.push_back(cyc);
      end
      if (frame_err)  n_ferr++;
      if (overrun)    n_ovr++;
      if (parity_err) n_perr++;
      if ((int'(push) + int'(frame_err) + int'(overrun) + int'(parity_err)) > 1) n_excl++;
      if ((push && prev_push) || (frame_err && prev_ferr) ||
          (overrun && prev_ovr) || (parity_err && prev_perr)) n_long++;
      if ((datainput !== prev_data) && !push) n_chg++;
      if (busy) busy_seen = 1'b1;
    end
    prev_push = push;
    prev_ferr = frame_err;
    prev_ovr  = overrun;
    prev_perr = parity_err;
    prev_data = datainput;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    push_q.delete();
    push_cyc_q.delete();
    n_ferr = 0; n_ovr = 0; n_perr = 0;
    n_excl = 0; n_long = 0; n_chg = 0;
    busy_seen = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) tick();
  endtask

  // Drives one frame; full is held at full_stop from the stop bit onward.
  // The line is left at the stop-bit level.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop, input logic par,
                            input logic full_stop, input bit jitter_full,
                            output int unsigned t0);
    t0 = cyc;
    send_bit(1'b0);
    for (int i = 0; i < int'(DW); i++) begin
      if (jitter_full) full = 1'($urandom_range(0, 1));
      send_bit(d[i]);
    end
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`endif
    full = full_stop;
    send_bit(stop);
  endtask

  // Outcome of a frame from its fields; frame error first, then parity, then full.
  function automatic int outcome(input logic [DW-1:0] d, input logic stop,
                                 input logic par, input logic f);
    if (!stop) return OUT_FERR;
`ifdef UART_RX_PARITY_EN
    if (((^d) ^ par) != 1'b0) return OUT_PERR;
`endif
    if (f) return OUT_OVR;
    return OUT_PUSH;
  endfunction

  task automatic test_reset();
    reset = 1'b0; rx = 1'b1; full = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (datainput !== 8'h00) begin
      n_fail++; $display("FAIL reset_data: got %0h expected 00", datainput);
    end
    n_checks++;
    if ({push, frame_err, overrun, parity_err, busy} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000",
                         {push, frame_err, overrun, parity_err, busy});
    end
    reset = 1'b1;
    clear_mon();
    repeat (100) tick();
    n_checks++;
    if ((push_q.size() + n_ferr + n_ovr + n_perr) != 0) begin
      n_fail++; $display("FAIL idle_pulses: got %0d expected 0",
                         push_q.size() + n_ferr + n_ovr + n_perr);
    end
    n_checks++;
    if (busy_seen !== 1'b0) begin
      n_fail++; $display("FAIL idle_busy: got %b expected 0", busy_seen);
    end
    n_checks++;
    if (datainput !== 8'h00) begin
      n_fail++; $display("FAIL idle_data: got %0h expected 00", datainput);
    end
    exp_data = 8'h00;
  endtask

  task automatic test_back_to_back();
    int unsigned ta, tb;
    clear_mon();
    send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0, 1'b0, ta);
    send_frame(8'h3C, 1'b1, ^8'h3C, 1'b0, 1'b0, tb);
    repeat (CPB) tick();
    exp_data = 8'h3C;
    n_checks++;
    if (push_q.size() != 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d expected 2", push_q.size());
    end else begin
      n_checks++;
      if (push_q[0] !== 8'hA5) begin
        n_fail++; $display("FAIL b2b_first: got %0h expected a5", push_q[0]);
      end
      n_checks++;
      if (push_q[1] !== 8'h3C) begin
        n_fail++; $display("FAIL b2b_second: got %0h expected 3c", push_q[1]);
      end
      n_checks++;
      if (push_cyc_q[0] - ta != LAT) begin
        n_fail++; $display("FAIL b2b_latency_first: got %0d expected %0d", push_cyc_q[0] - ta, LAT);
      end
      n_checks++;
      if (push_cyc_q[1] - tb != LAT) begin
        n_fail++; $display("FAIL b2b_latency_second: got %0d expected %0d", push_cyc_q[1] - tb, LAT);
      end
    end
    n_checks++;
    if (datainput !== exp_data) begin
      n_fail++; $display("FAIL b2b_hold: got %0h expected %0h", datainput, exp_data);
    end
    n_checks++;
    if ((n_ferr + n_ovr + n_perr + n_excl + n_long + n_chg) != 0) begin
      n_fail++; $display("FAIL b2b_side_effects: got %0d expected 0",
                         n_ferr + n_ovr + n_perr + n_excl + n_long + n_chg);
    end
  endtask

  task automatic test_overrun();
    int unsigned t;
    clear_mon();
    send_frame(8'h5A, 1'b1, ^8'h5A, 1'b1, 1'b0, t);
    full = 1'b0;
    repeat (CPB) tick();
    n_checks++;
    if (n_ovr != 1) begin
      n_fail++; $display("FAIL overrun_count: got %0d expected 1", n_ovr);
    end
    n_checks++;
    if (push_q.size() != 0) begin
      n_fail++; $display("FAIL overrun_push: got %0d expected 0", push_q.size());
    end
    n_checks++;
    if (datainput !== exp_data) begin
      n_fail++; $display("FAIL overrun_data: got %0h expected %0h", datainput, exp_data);
    end
  endtask

  task automatic test_break();
    int unsigned t;
    clear_mon();
    send_frame(8'hFF, 1'b0, ^8'hFF, 1'b0, 1'b0, t);
    repeat (64) tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL break_busy: got %b expected 1", busy);
    end
    rx = 1'b1;
    repeat (CPB) tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL break_release_busy: got %b expected 0", busy);
    end
    send_frame(8'h01, 1'b1, ^8'h01, 1'b0, 1'b0, t);
    repeat (CPB) tick();
    exp_data = 8'h01;
    n_checks++;
    if (n_ferr != 1) begin
      n_fail++; $display("FAIL break_ferr_count: got %0d expected 1", n_ferr);
    end
    n_checks++;
    if (push_q.size() != 1) begin
      n_fail++; $display("FAIL break_push_count: got %0d expected 1", push_q.size());
    end else begin
      n_checks++;
      if (push_q[0] !== 8'h01) begin
        n_fail++; $display("FAIL break_next_data: got %0h expected 01", push_q[0]);
      end
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (3 * CPB) tick();
    n_checks++;
    if ((push_q.size() + n_ferr + n_ovr + n_perr) != 0) begin
      n_fail++; $display("FAIL glitch_pulses: got %0d expected 0",
                         push_q.size() + n_ferr + n_ovr + n_perr);
    end
    n_checks++;
    if ({busy_seen, busy} !== 2'b10) begin
      n_fail++; $display("FAIL glitch_busy: got seen=%b now=%b expected seen=1 now=0", busy_seen, busy);
    end
  endtask

  task automatic test_reset_mid();
    int unsigned t;
    logic [DW-1:0] d;
    d = 8'hC3;
    clear_mon();
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    reset = 1'b0;
    rx = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({busy, datainput} !== 9'h000) begin
      n_fail++; $display("FAIL midreset_state: got busy=%b data=%0h expected 0/00", busy, datainput);
    end
    reset = 1'b1;
    exp_data = 8'h00;
    repeat (CPB) tick();
    send_frame(8'h12, 1'b1, ^8'h12, 1'b0, 1'b0, t);
    repeat (CPB) tick();
    exp_data = 8'h12;
    n_checks++;
    if (push_q.size() != 1) begin
      n_fail++; $display("FAIL midreset_push_count: got %0d expected 1", push_q.size());
    end else begin
      n_checks++;
      if (push_q[0] !== 8'h12) begin
        n_fail++; $display("FAIL midreset_data: got %0h expected 12", push_q[0]);
      end
    end
    n_checks++;
    if ((n_ferr + n_ovr + n_perr) != 0) begin
      n_fail++; $display("FAIL midreset_errors: got %0d expected 0", n_ferr + n_ovr + n_perr);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_q[$];
    int            e_ferr, e_ovr, e_perr;
    int unsigned   t;
    logic [DW-1:0] d;
    logic          stop, par, fs;
    int            o;
    clear_mon();
    e_ferr = 0; e_ovr = 0; e_perr = 0;
    for (int k = 0; k < 20; k++) begin
      d    = DW'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      fs   = 1'($urandom_range(0, 1));
      par  = ^d;
`ifdef UART_RX_PARITY_EN
      if ($urandom_range(0, 3) == 0) par = ~par;
`endif
      o = outcome(d, stop, par, fs);
      case (o)
        OUT_PUSH: begin exp_q.push_back(d); exp_data = d; end
        OUT_FERR: e_ferr++;
        OUT_PERR: e_perr++;
        default:  e_ovr++;
      endcase
      send_frame(d, stop, par, fs, 1'b1, t);
      if (!stop) begin
        repeat ($urandom_range(0, CPB)) tick();
        rx = 1'b1;
        repeat ($urandom_range(CPB, 2 * CPB)) tick();
      end else begin
        repeat ($urandom_range(0, 2 * CPB)) tick();
      end
    end
    full = 1'b0;
    repeat (CPB) tick();
    n_checks++;
    if (push_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_push_count: got %0d expected %0d", push_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (push_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand_data[%0d]: got %0h expected %0h", i, push_q[i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if ({n_ferr, n_ovr, n_perr} !== {e_ferr, e_ovr, e_perr}) begin
      n_fail++; $display("FAIL rand_err_counts: got ferr=%0d ovr=%0d perr=%0d expected %0d/%0d/%0d",
                         n_ferr, n_ovr, n_perr, e_ferr, e_ovr, e_perr);
    end
    n_checks++;
    if ((n_excl + n_long + n_chg) != 0) begin
      n_fail++; $display("FAIL rand_strobe_rules: got excl=%0d long=%0d chg=%0d expected 0",
                         n_excl, n_long, n_chg);
    end
    n_checks++;
    if (datainput !== exp_data) begin
      n_fail++; $display("FAIL rand_hold: got %0h expected %0h", datainput, exp_data);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int unsigned t;
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0, t);
    repeat (CPB) tick();
    n_checks++;
    if ({n_perr, push_q.size()} !== {32'sd1, 32'sd0}) begin
      n_fail++; $display("FAIL parity_bad: got perr=%0d push=%0d expected 1/0", n_perr, push_q.size());
    end
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, t);
    repeat (CPB) tick();
    exp_data = 8'h07;
    n_checks++;
    if (push_q.size() != 1) begin
      n_fail++; $display("FAIL parity_good_count: got %0d expected 1", push_q.size());
    end else begin
      n_checks++;
      if (push_q[0] !== 8'h07) begin
        n_fail++; $display("FAIL parity_good_data: got %0h expected 07", push_q[0]);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b0; rx = 1'b1; full = 1'b0;
    test_reset();
    test_back_to_back();
    test_overrun();
    test_break();
    test_glitch();
    test_reset_mid();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
